vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA controller. It derives a pixel-clock enable from CLOCK_50 and generates h/v counters, sync, blank and frame-start signals, with configurable timing and sync polarity. Sync and blank are delayed to match a configurable RGB-source pipeline latency, so image and font memories clocked on !CLOCK_50 line up without per-design fixes. Adds a built-in test-pattern mode that is selected once per frame.

Parameters:
CLK_DIV, 2, CLOCK_50 cycles per pixel; 2 gives a 25 MHz pixel rate; must be at least 1
H_ACTIVE, 640, visible pixels per line
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in pixels
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch in lines
HS_POL / VS_POL, 0 / 0, asserted sync level; 0 means active-low
COLOR_BITS, 1, bits per colour channel
PIPE_LAT, 1, pixel ticks from x/y issue to valid rgb_in; range 0..7
CW, 10, coordinate width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
rgb_in  in  3*COLOR_BITS  {r,g,b} from the pixel source, valid PIPE_LAT ticks after x/y
pattern_sel  in  2  0 = external, 1 = colour bars, 2 = checker, 3 = black
x  out  CW  current horizontal counter (address for the RGB generator)
y  out  CW  current vertical counter
pix_en  out  1  one-CLOCK_50-cycle pixel tick
VGA_HS  out  1  horizontal sync, aligned to the colour outputs
VGA_VS  out  1  vertical sync, aligned to the colour outputs
VGA_R / VGA_G / VGA_B  out  COLOR_BITS each  colour outputs, forced to 0 while blanked
active  out  1  visible-region flag, aligned to the colour outputs
frame_start  out  1  one-cycle pulse at counter (0,0)
frame_cnt  out  8  frames since reset, wraps 255 -> 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL likewise.
- Reset (asynchronous): divider = 0, x = y = 0, pix_en = 0, frame_cnt = 0, frame_start = 0, active = 0, colour outputs = 0.
- Reset, syncs and pipeline: VGA_HS = ~HS_POL, VGA_VS = ~VS_POL, all delay stages cleared to blanked/deasserted values, latched pattern = 0.
- Reset released mid-frame: restart from (0,0) with no glitch pulse on the syncs.
- Divider: counts 0..CLK_DIV-1; pix_en = 1 in the cycle the divider equals CLK_DIV-1; with CLK_DIV = 1, pix_en is held at 1.
- Counters advance only on pix_en.
  - x wraps H_TOTAL-1 -> 0; y increments on x wrap.
  - y wraps V_TOTAL-1 -> 0 when x also wraps.
- frame_start = 1 for exactly the pix_en cycle in which x = 0 and y = 0 (the first tick after reset included).
  - frame_cnt increments at the same edge.
  - pattern_sel is latched on that tick only; changes mid-frame take effect at the next frame.
- Issue-stage decode of (x, y), combinational:
  - hs_i = (x >= H_ACTIVE+H_FP) and (x < H_ACTIVE+H_FP+H_SYNC); vs_i is the same form on y.
  - act_i = (x < H_ACTIVE) and (y < V_ACTIVE).
  - pattern colour: bars use index x / (H_ACTIVE/8), each bit replicated to COLOR_BITS as {r = idx[2], g = idx[1], b = idx[0]}; checker is white when x[5] ^ y[5] = 1, else black.
- Delay line: hs_i, vs_i, act_i and the pattern colour pass through PIPE_LAT stages, each enabled by pix_en.
- Output register, updated on pix_en:
  - Sync pins: VGA_HS = delayed hs ? HS_POL : ~HS_POL; VGA_VS likewise with VS_POL.
  - Visibility: active = delayed act.
  - Colour: if delayed act is 0, outputs are 0; otherwise rgb_in when the latched pattern is 0, the delayed pattern colour when it is 1 or 2, and 0 when it is 3.
- Latency: an (x, y) issued on tick t appears on the VGA pins at tick t+PIPE_LAT+1; rgb_in is sampled on tick t+PIPE_LAT.
- Between pix_en ticks all outputs hold their values.

Decomposition:
- Package vga_pkg holds the default 640x480@60 timing constants, pattern_sel encodings (PAT_EXT, PAT_BARS, PAT_CHECK, PAT_BLACK) and an H_TOTAL/V_TOTAL computation function.
- Sub-module vga_delay_line (parameters WIDTH and DEPTH; ports CLOCK_50, reset, en, d, q). With DEPTH = 0 it is a wire.

Test Plan:
- Defaults, 2 frames -> frame_start period = 840000 CLOCK_50 cycles; frame_cnt goes 1 then 2; pix_en period = 2 cycles.
- Defaults, one line -> VGA_HS low for 96 pixel ticks, falling 658 ticks after the x = 0 tick (656 + PIPE_LAT + 1); VGA_VS low for 2 lines.
- pattern_sel = 0, rgb_in = 3'b101 held -> colour outputs = 101 only while active = 1, and 000 during porches and sync.
- pattern_sel = 1 -> visible pixels 0..79 give 000, 80..159 give 001, ..., 560..639 give 111.
- pattern_sel changed from 0 to 2 at y = 100 -> no change until the next frame_start; then pixel (32,0) is white and (32,32) is black.
- reset pulsed mid-line at x = 300 -> all outputs go to reset values asynchronously; after release the first pix_en produces frame_start; repeat with HS_POL = 1, CLK_DIV = 1, PIPE_LAT = 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: default 640x480@60
// timing, test-pattern encodings and a line/frame total helper.
package vga_pkg;

    // Default 640x480@60 timing (25 MHz pixel clock from a 50 MHz system clock)
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Pixel source selected by pattern_sel, latched once per frame
    typedef enum logic [1:0] {
        PAT_EXT   = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BLACK = 2'd3
    } pattern_e;

    // Total pixels per line or lines per frame
    function automatic int unsigned timing_total(
        input int unsigned active_len,
        input int unsigned fp_len,
        input int unsigned sync_len,
        input int unsigned bp_len
    );
        return active_len + fp_len + sync_len + bp_len;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Pixel-tick-enabled delay line used to align sync/blank/pattern data with
// the latency of the external RGB source. DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock, reset and enable are not needed when the line is a plain wire
            logic unused_ctrl;
            assign unused_ctrl = CLOCK_50 ^ reset ^ en;
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift one stage per pixel tick
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                // NOTE: every stage is reset because it carries sync and blank
                // state; leaving it unreset would emit sync glitches after reset.
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else if (en) begin
                    stage_q[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock enable, h/v counters,
// sync/blank decode delayed to match the RGB source latency, per-frame
// latched test patterns and a frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned COLOR_BITS = 1,
    parameter int unsigned PIPE_LAT   = 1,
    parameter int unsigned CW         = 10
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [3*COLOR_BITS-1:0] rgb_in,
    input  logic [1:0]              pattern_sel,
    output logic [CW-1:0]           x,
    output logic [CW-1:0]           y,
    output logic                    pix_en,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic [COLOR_BITS-1:0]   VGA_R,
    output logic [COLOR_BITS-1:0]   VGA_G,
    output logic [COLOR_BITS-1:0]   VGA_B,
    output logic                    active,
    output logic                    frame_start,
    output logic [7:0]              frame_cnt
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RGB_W   = 3 * COLOR_BITS;
    localparam int unsigned DL_W    = 3 + RGB_W;

    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT        = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT        = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_W        = CW'(H_ACTIVE / 8);

    // Divider and counter state
    logic [DW-1:0]    div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [CW-1:0]    x_q, x_d;
    logic [CW-1:0]    y_q, y_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    pattern_e         pat_q, pat_d;
    logic             frame_start_c;

    // Issue-stage decode
    pattern_e         pat_issue;
    logic             hs_i, vs_i, act_i;
    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] pat_rgb;

    // Delayed decode
    logic [DL_W-1:0]  dl_d, dl_q;
    logic             hs_p, vs_p, act_p;
    logic [RGB_W-1:0] pat_rgb_p;

    // Output register
    logic             hs_q, vs_q, act_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    // A frame begins on the tick that sees the counters at the origin
    assign frame_start_c = pix_en_q && (x_q == '0) && (y_q == '0);

    // Divider next state; the tick is registered so it lines up with the last count
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        pix_en_d = (div_d == DIV_LAST);
    end

    // Counter, frame count and pattern latch next state, advanced only on a tick
    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path
        // through the conditionals leaves it unassigned and infers a latch.
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        if (pix_en_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
            if (frame_start_c) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                pat_d       = pattern_e'(pattern_sel);
            end
        end
    end

    // Divider, tick, counters and the per-frame pattern latch
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            div_q       <= '0;
            pix_en_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            pat_q       <= PAT_EXT;
        end else begin
            div_q       <= div_d;
            pix_en_q    <= pix_en_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
        end
    end

    // On the frame-start tick the new selection is not latched yet, so use it directly
    assign pat_issue = frame_start_c ? pattern_e'(pattern_sel) : pat_q;

    assign hs_i    = (x_q >= H_SYNC_START) && (x_q < H_SYNC_END);
    assign vs_i    = (y_q >= V_SYNC_START) && (y_q < V_SYNC_END);
    assign act_i   = (x_q < H_ACT) && (y_q < V_ACT);
    assign bar_idx = 3'(x_q / BAR_W);

    // Built-in pattern colour for the coordinate being issued
    always_comb begin
        pat_rgb = '0;
        case (pat_issue)
            PAT_BARS:  pat_rgb = {{COLOR_BITS{bar_idx[2]}},
                                  {COLOR_BITS{bar_idx[1]}},
                                  {COLOR_BITS{bar_idx[0]}}};
            PAT_CHECK: pat_rgb = {RGB_W{x_q[5] ^ y_q[5]}};
            default:   pat_rgb = '0;
        endcase
    end

    assign dl_d = {hs_i, vs_i, act_i, pat_rgb};

    vga_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (pix_en_q),
        .d        (dl_d),
        .q        (dl_q)
    );

    assign {hs_p, vs_p, act_p, pat_rgb_p} = dl_q;

    // Colour mux: blanked pixels are black, otherwise source chosen by the latched pattern
    always_comb begin
        rgb_d = '0;
        if (act_p) begin
            case (pat_q)
                PAT_EXT:             rgb_d = rgb_in;
                PAT_BARS, PAT_CHECK: rgb_d = pat_rgb_p;
                default:             rgb_d = '0;
            endcase
        end
    end

    // Output register, updated once per pixel tick
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            act_q <= 1'b0;
            rgb_q <= '0;
        end else if (pix_en_q) begin
            hs_q  <= hs_p ? HS_POL : ~HS_POL;
            vs_q  <= vs_p ? VS_POL : ~VS_POL;
            act_q <= act_p;
            rgb_q <= rgb_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_en      = pix_en_q;
    assign frame_start = frame_start_c;
    assign frame_cnt   = frame_cnt_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign active      = act_q;
    assign VGA_R       = rgb_q[3*COLOR_BITS-1 -: COLOR_BITS];
    assign VGA_G       = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign VGA_B       = rgb_q[COLOR_BITS-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster (144x46 totals)
// so whole frames fit in a short run. dut0: CLK_DIV=2, PIPE_LAT=2,
// active-low syncs. dut1: CLK_DIV=1, PIPE_LAT=0, active-high HS.
module tb_vga_timing_gen;

    localparam int HA    = 128;
    localparam int HFP   = 4;
    localparam int HSW   = 8;
    localparam int HBP   = 4;
    localparam int HT    = 144;
    localparam int VA    = 40;
    localparam int VFP   = 2;
    localparam int VSW   = 2;
    localparam int VBP   = 2;
    localparam int VT    = 46;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst0 = 1'b0;
    logic       rst1 = 1'b0;
    logic [2:0] rgb_in = 3'b101;
    logic [1:0] pattern_sel = 2'd0;

    logic [7:0] x0, y0, frame_cnt0;
    logic       pix_en0, HS0, VS0, R0, G0, B0, active0, frame_start0;
    logic [7:0] x1, y1, frame_cnt1;
    logic       pix_en1, HS1, VS1, R1, G1, B1, active1, frame_start1;
    logic [2:0] rgb0, rgb1;

    assign rgb0 = {R0, G0, B0};
    assign rgb1 = {R1, G1, B1};

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_BITS(1), .PIPE_LAT(2), .CW(8)
    ) dut0 (
        .CLOCK_50(clk), .reset(rst0), .rgb_in(rgb_in), .pattern_sel(pattern_sel),
        .x(x0), .y(y0), .pix_en(pix_en0), .VGA_HS(HS0), .VGA_VS(VS0),
        .VGA_R(R0), .VGA_G(G0), .VGA_B(B0), .active(active0),
        .frame_start(frame_start0), .frame_cnt(frame_cnt0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_BITS(1), .PIPE_LAT(0), .CW(8)
    ) dut1 (
        .CLOCK_50(clk), .reset(rst1), .rgb_in(rgb_in), .pattern_sel(pattern_sel),
        .x(x1), .y(y1), .pix_en(pix_en1), .VGA_HS(HS1), .VGA_VS(VS1),
        .VGA_R(R1), .VGA_G(G1), .VGA_B(B1), .active(active1),
        .frame_start(frame_start1), .frame_cnt(frame_cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int k0, k1;
    int last_tick_cyc, tick_gap, fs_cyc;
    int hs_low, hs_fall, vs_low, vs_fall, act_n, act_bad, blank_bad, fs_extra, gap_bad, glitch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance dut0 to its next pixel tick (bounded), sampling on the falling edge
    task automatic tick0();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_en0 && n < 6);
        if (!pix_en0) check("tick0_timeout", 32'(pix_en0), 32'd1);
        tick_gap      = cyc - last_tick_cyc;
        last_tick_cyc = cyc;
        k0            = (k0 + 1) % FRAME;
    endtask

    task automatic walk0_to(input int target);
        while (k0 != target) tick0();
    endtask

    // dut1 ticks every cycle once out of reset
    task automatic tick1();
        @(negedge clk);
        if (!pix_en1) check("tick1_en", 32'(pix_en1), 32'd1);
        k1++;
    endtask

    task automatic walk1_to(input int target);
        while (k1 < target) tick1();
    endtask

    initial begin
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        check("rst_xy0", 32'({x0, y0}), 32'd0);
        check("rst_ctl0", 32'({pix_en0, frame_start0, active0, HS0, VS0}), 32'b00011);
        check("rst_rgb0", 32'(rgb0), 32'd0);
        check("rst_fcnt0", 32'(frame_cnt0), 32'd0);
        check("rst_ctl1", 32'({pix_en1, frame_start1, active1, HS1, VS1}), 32'b00001);

        // Frame 1 on dut0: external colour 101
        rst0 = 1'b0;
        k0 = -1;
        last_tick_cyc = cyc;
        tick0();
        check("fs_first", 32'(frame_start0), 32'd1);
        check("xy_first", 32'({x0, y0}), 32'd0);
        check("fcnt_first", 32'(frame_cnt0), 32'd0);
        fs_cyc = cyc;

        hs_low = 0; hs_fall = -1; vs_low = 0; vs_fall = -1;
        act_n = 0; act_bad = 0; blank_bad = 0; fs_extra = 0; gap_bad = 0;
        for (int i = 1; i < FRAME; i++) begin
            tick0();
            if (tick_gap != 2) gap_bad++;
            if (frame_start0) fs_extra++;
            if (i < HT && !HS0) begin
                hs_low++;
                if (hs_fall < 0) hs_fall = i;
            end
            if (!VS0) begin
                vs_low++;
                if (vs_fall < 0) vs_fall = i;
            end
            if (active0) begin
                act_n++;
                if (rgb0 != 3'b101) act_bad++;
            end else if (rgb0 != 3'b000) begin
                blank_bad++;
            end
            if (i == 1) begin
                check("fcnt_after_fs1", 32'(frame_cnt0), 32'd1);
                check("xy_k1", 32'({x0, y0}), 32'h0100);
            end
            if (i == HT + 1) check("xy_next_line", 32'({x0, y0}), 32'h0101);
            if (i == 20 * HT) pattern_sel = 2'd2;
        end
        check("pix_en_period", 32'(gap_bad), 32'd0);
        check("fs_extra", 32'(fs_extra), 32'd0);
        check("hs_fall", 32'(hs_fall), 32'(HA + HFP + 3));
        check("hs_low_len", 32'(hs_low), 32'(HSW));
        check("vs_fall", 32'(vs_fall), 32'((VA + VFP) * HT + 3));
        check("vs_low_len", 32'(vs_low), 32'(VSW * HT));
        check("active_count", 32'(act_n), 32'(HA * VA));
        check("active_rgb_bad", 32'(act_bad), 32'd0);
        check("blank_rgb_bad", 32'(blank_bad), 32'd0);

        // Frame 2: checker pattern latched at this frame start
        tick0();
        check("fs_second", 32'(frame_start0), 32'd1);
        check("frame_period", 32'(cyc - fs_cyc), 32'(2 * FRAME));
        check("fcnt_at_fs2", 32'(frame_cnt0), 32'd1);
        walk0_to(34);
        check("chk_31_0", 32'({active0, rgb0}), 32'b1000);
        walk0_to(35);
        check("chk_32_0", 32'({active0, rgb0}), 32'b1111);
        check("fcnt_frame2", 32'(frame_cnt0), 32'd2);
        walk0_to(32 * HT + 3);
        check("chk_0_32", 32'({active0, rgb0}), 32'b1111);
        walk0_to(32 * HT + 35);
        check("chk_32_32", 32'({active0, rgb0}), 32'b1000);
        pattern_sel = 2'd1;

        // Frame 3: colour bars, 16 pixels wide each
        walk0_to(0);
        check("fs_third", 32'(frame_start0), 32'd1);
        walk0_to(3);
        check("bar_x0", 32'({active0, rgb0}), 32'b1000);
        walk0_to(19);
        check("bar_x16", 32'({active0, rgb0}), 32'b1001);
        walk0_to(43);
        check("bar_x40", 32'({active0, rgb0}), 32'b1010);
        walk0_to(130);
        check("bar_x127", 32'({active0, rgb0}), 32'b1111);
        walk0_to(131);
        check("bar_x128_blank", 32'({active0, rgb0}), 32'b0000);
        walk0_to(HT + 103);
        check("mid_x", 32'(x0), 32'd103);
        check("bar_line1_x100", 32'({active0, rgb0}), 32'b1110);

        // Asynchronous reset mid-line on dut0
        #1 rst0 = 1'b1;
        #1;
        check("arst_xy0", 32'({x0, y0}), 32'd0);
        check("arst_ctl0", 32'({pix_en0, frame_start0, active0, HS0, VS0}), 32'b00011);
        check("arst_rgb0", 32'(rgb0), 32'd0);
        check("arst_fcnt0", 32'(frame_cnt0), 32'd0);
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        k0 = -1;
        tick0();
        check("fs_after_rst0", 32'({frame_start0, x0, y0}), 32'h10000);
        glitch = 0;
        for (int i = 0; i < 20; i++) begin
            if (!HS0 || !VS0) glitch++;
            tick0();
        end
        check("sync_glitch0", 32'(glitch), 32'd0);

        // dut1: CLK_DIV=1, PIPE_LAT=0, active-high HS
        @(negedge clk);
        rst1 = 1'b0;
        k1 = -1;
        tick1();
        check("fs_first1", 32'({frame_start1, x1, y1}), 32'h10000);
        walk1_to(HA + HFP);
        check("hs1_before", 32'(HS1), 32'd0);
        walk1_to(HA + HFP + 1);
        check("hs1_rise", 32'(HS1), 32'd1);
        walk1_to(HA + HFP + HSW);
        check("hs1_last", 32'(HS1), 32'd1);
        walk1_to(HA + HFP + HSW + 1);
        check("hs1_fall", 32'(HS1), 32'd0);
        walk1_to(HT + 100);
        check("bar1_line1_x99", 32'({active1, rgb1}), 32'b1110);
        check("fcnt1", 32'(frame_cnt1), 32'd1);
        #1 rst1 = 1'b1;
        #1;
        check("arst_ctl1", 32'({pix_en1, frame_start1, active1, HS1, VS1}), 32'b00001);
        check("arst_rgb1", 32'({rgb1, frame_cnt1}), 32'd0);
        check("arst_xy1", 32'({x1, y1}), 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        k1 = -1;
        tick1();
        check("fs_after_rst1", 32'({frame_start1, frame_cnt1}), 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
